mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, 32, data and address width in bits.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port i_req_valid  input  1  fetch requester read request.
REQ-005 Port i_req_ready  output  1  fetch request accepted this cycle.
REQ-006 Port i_addr  input  WIDTH  fetch byte address.
REQ-007 Port i_resp_valid  output  1  fetch read data valid, one-cycle pulse.
REQ-008 Port i_rdata  output  WIDTH  fetch read data.
REQ-009 Port d_req_valid  input  1  data requester request.
REQ-010 Port d_req_ready  output  1  data request accepted this cycle.
REQ-011 Port d_addr  input  WIDTH  data byte address.
REQ-012 Port d_we  input  1  1 = store, 0 = load.
REQ-013 Port d_wdata  input  WIDTH  store data, already lane-shifted.
REQ-014 Port d_be  input  4  store byte enables, already lane-shifted.
REQ-015 Port d_resp_valid  output  1  load data valid or store complete, one-cycle pulse.
REQ-016 Port d_rdata  output  WIDTH  load data, full word, unshifted.
REQ-017 Port ram_addr  output  WIDTH  shared RAM address.
REQ-018 Port ram_we  output  1  shared RAM write enable.
REQ-019 Port ram_wd  output  WIDTH  shared RAM write data.
REQ-020 Port ram_be  output  4  shared RAM byte enables.
REQ-021 Port ram_rd  input  WIDTH  RAM read data, valid one cycle after address (synchronous read).

Function
REQ-022 FSM states IDLE, ACCESS, RESP; transitions IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-023 Accept only in IDLE; i_req_ready/d_req_ready are combinational, at most one high per cycle, both 0 outside IDLE.
REQ-024 Arbitration: single valid requester is granted; both valid -> grant the port not granted last (round-robin flag last_grant).
REQ-025 last_grant updates only on accept; reset value D, so I wins first contention.
REQ-026 On accept (valid && ready, cycle T) latch addr, we, wdata, be and owner; fetch latches we=0, be=4'b0000, wdata=0.
REQ-027 T+1 (ACCESS): ram_addr=latched addr, ram_we=latched we, ram_wd=latched wdata, ram_be=latched be.
REQ-028 Outside ACCESS: ram_we=0, ram_be=0; ram_addr and ram_wd hold latched values.
REQ-029 T+2 (RESP): owner's resp_valid=1 for exactly one cycle; other port's resp_valid=0.
REQ-030 In RESP for a load/fetch, owner's rdata=ram_rd combinationally; for a store, d_rdata=0.
REQ-031 i_rdata/d_rdata are 0 whenever the port's resp_valid is 0.
REQ-032 Latency request-accept to response exactly 2 cycles; peak throughput one transaction per 3 cycles.
REQ-033 Requesters hold valid and payload stable until ready; dropping valid before ready is legal and cancels the request, no side effect.
REQ-034 Valid asserted in ACCESS/RESP is not accepted; it is arbitrated in the next IDLE cycle.
REQ-035 No address alignment check; d_be and addresses pass through unmodified.

Reset
REQ-036 rst_n low, asynchronously: state=IDLE, last_grant=D, all latches 0, all outputs 0 except ready outputs, which follow REQ-023 combinationally.
REQ-037 Reset during ACCESS or RESP aborts the transaction: no resp_valid pulse, ram_we drops immediately.

Verification
REQ-038 Fetch only: i_req_valid=1, i_addr=0x10, ram_rd=0xDEADBEEF at T+2 -> i_req_ready at T, ram_addr=0x10 at T+1, i_resp_valid=1, i_rdata=0xDEADBEEF at T+2.
REQ-039 Store: d_we=1, d_addr=0x22, d_wdata=0x00AB0000, d_be=4'b0100 -> ram_we=1, ram_be=4'b0100, ram_wd=0x00AB0000 at T+1 only; d_resp_valid=1, d_rdata=0 at T+2.
REQ-040 Contention from reset: both valid continuously -> grants I, D, I, D at cycles 0, 3, 6, 9.
REQ-041 Valid in ACCESS: d_req_valid rises at T+1 of a fetch -> d_req_ready=0 until T+3, accepted at T+3.
REQ-042 Reset mid-store: rst_n low during ACCESS -> ram_we=0 that cycle, no d_resp_valid, next accept after release behaves as REQ-038.
REQ-043 Withdrawn request: d_req_valid high one cycle while busy, then low -> no RAM access, no d_resp_valid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both requester ports and the shared RAM port of mem_arbiter.
// master = requesters plus RAM read data (bench side), slave = the arbiter.
interface mem_arbiter_if #(parameter int WIDTH = 32);
    logic             i_req_valid;
    logic             i_req_ready;
    logic [WIDTH-1:0] i_addr;
    logic             i_resp_valid;
    logic [WIDTH-1:0] i_rdata;
    logic             d_req_valid;
    logic             d_req_ready;
    logic [WIDTH-1:0] d_addr;
    logic             d_we;
    logic [WIDTH-1:0] d_wdata;
    logic [3:0]       d_be;
    logic             d_resp_valid;
    logic [WIDTH-1:0] d_rdata;
    logic [WIDTH-1:0] ram_addr;
    logic             ram_we;
    logic [WIDTH-1:0] ram_wd;
    logic [3:0]       ram_be;
    logic [WIDTH-1:0] ram_rd;

    modport master (
        output i_req_valid, i_addr, d_req_valid, d_addr, d_we, d_wdata, d_be, ram_rd,
        input  i_req_ready, i_resp_valid, i_rdata, d_req_ready, d_resp_valid, d_rdata,
               ram_addr, ram_we, ram_wd, ram_be
    );

    modport slave (
        input  i_req_valid, i_addr, d_req_valid, d_addr, d_we, d_wdata, d_be, ram_rd,
        output i_req_ready, i_resp_valid, i_rdata, d_req_ready, d_resp_valid, d_rdata,
               ram_addr, ram_we, ram_wd, ram_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous-read RAM between fetch and data ports.
// One transaction at a time: IDLE (accept) -> ACCESS (drive RAM) -> RESP (return data).
module mem_arbiter #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t           state_q, state_d;
    logic             last_d_q;
    logic             we_q;
    logic [WIDTH-1:0] addr_q, wd_q;
    logic [3:0]       be_q, ram_be_q;
    logic             ram_we_q, i_resp_q, d_resp_q;
    logic             grant_i, grant_d, accept;

    // last_d_q doubles as the owner of the in-flight transaction
    always_comb begin
        grant_i = (state_q == IDLE) && bus.i_req_valid && (!bus.d_req_valid || last_d_q);
        grant_d = (state_q == IDLE) && bus.d_req_valid && !grant_i;
        accept  = grant_i || grant_d;
        state_d = accept ? ACCESS : (state_q == ACCESS) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wd_q     <= '0;
            be_q     <= '0;
            ram_we_q <= 1'b0;
            ram_be_q <= '0;
            i_resp_q <= 1'b0;
            d_resp_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_d_q <= grant_d;
                addr_q   <= grant_d ? bus.d_addr : bus.i_addr;
                we_q     <= grant_d && bus.d_we;
                wd_q     <= grant_d ? bus.d_wdata : '0;
                be_q     <= grant_d ? bus.d_be : 4'b0000;
            end
            ram_we_q <= grant_d && bus.d_we;
            ram_be_q <= grant_d ? bus.d_be : 4'b0000;
            i_resp_q <= (state_q == ACCESS) && !last_d_q;
            d_resp_q <= (state_q == ACCESS) && last_d_q;
        end
    end

    assign bus.i_req_ready  = grant_i;
    assign bus.d_req_ready  = grant_d;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wd       = wd_q;
    assign bus.ram_we       = ram_we_q;
    assign bus.ram_be       = ram_be_q;
    assign bus.i_resp_valid = i_resp_q;
    assign bus.d_resp_valid = d_resp_q;
    assign bus.i_rdata      = i_resp_q ? bus.ram_rd : '0;
    assign bus.d_rdata      = (d_resp_q && !we_q) ? bus.ram_rd : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors with hand-computed expectations for mem_arbiter.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic seen_we, seen_dresp;

    mem_arbiter_if #(.WIDTH(32)) bus ();

    mem_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        bus.i_req_valid = 1'b0;
        bus.i_addr      = '0;
        bus.d_req_valid = 1'b0;
        bus.d_addr      = '0;
        bus.d_we        = 1'b0;
        bus.d_wdata     = '0;
        bus.d_be        = 4'b0000;
    endtask

    task automatic fetch_0x10(input string tag);
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h10;
        bus.ram_rd      = 32'hDEADBEEF;
        #1;
        chk({tag, "_i_ready"}, bus.i_req_ready, 1);
        chk({tag, "_d_ready"}, bus.d_req_ready, 0);
        step();
        clear();
        chk({tag, "_ram_addr"}, bus.ram_addr, 32'h10);
        chk({tag, "_ram_we"}, bus.ram_we, 0);
        chk({tag, "_ram_be"}, bus.ram_be, 0);
        chk({tag, "_i_resp_early"}, bus.i_resp_valid, 0);
        step();
        chk({tag, "_i_resp"}, bus.i_resp_valid, 1);
        chk({tag, "_i_rdata"}, bus.i_rdata, 32'hDEADBEEF);
        chk({tag, "_d_resp"}, bus.d_resp_valid, 0);
        step();
        chk({tag, "_i_resp_off"}, bus.i_resp_valid, 0);
        chk({tag, "_i_rdata_off"}, bus.i_rdata, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear();
        bus.ram_rd = 32'hDEADBEEF;
        step();
        step();
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_ram_be", bus.ram_be, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        chk("rst_ram_wd", bus.ram_wd, 0);
        chk("rst_i_resp", bus.i_resp_valid, 0);
        chk("rst_d_resp", bus.d_resp_valid, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        bus.i_req_valid = 1'b1;
        #1;
        chk("rst_i_ready_comb", bus.i_req_ready, 1);
        clear();
        #1;
        chk("rst_i_ready_idle", bus.i_req_ready, 0);
        rst_n = 1'b1;
        step();

        fetch_0x10("fetch");

        // store, data port only
        bus.d_req_valid = 1'b1;
        bus.d_we        = 1'b1;
        bus.d_addr      = 32'h22;
        bus.d_wdata     = 32'h00AB0000;
        bus.d_be        = 4'b0100;
        #1;
        chk("st_d_ready", bus.d_req_ready, 1);
        chk("st_i_ready", bus.i_req_ready, 0);
        step();
        clear();
        chk("st_ram_we", bus.ram_we, 1);
        chk("st_ram_be", bus.ram_be, 4'b0100);
        chk("st_ram_wd", bus.ram_wd, 32'h00AB0000);
        chk("st_ram_addr", bus.ram_addr, 32'h22);
        step();
        chk("st_ram_we_off", bus.ram_we, 0);
        chk("st_ram_be_off", bus.ram_be, 0);
        chk("st_d_resp", bus.d_resp_valid, 1);
        chk("st_d_rdata", bus.d_rdata, 0);
        chk("st_i_resp", bus.i_resp_valid, 0);
        step();
        chk("st_d_resp_off", bus.d_resp_valid, 0);

        // contention straight out of reset: I, D, I, D
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h8;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h4;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr%0d_i_ready", k), bus.i_req_ready, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr%0d_d_ready", k), bus.d_req_ready, (k % 2 == 1) ? 1 : 0);
            step();
            chk($sformatf("rr%0d_busy_ready", k), bus.i_req_ready | bus.d_req_ready, 0);
            step();
            step();
        end
        clear();

        // data request raised during the ACCESS cycle of a fetch
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h30;
        #1;
        chk("acc_i_ready", bus.i_req_ready, 1);
        step();
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b1;
        bus.d_addr      = 32'h40;
        bus.ram_rd      = 32'h12345678;
        #1;
        chk("acc_d_ready_t1", bus.d_req_ready, 0);
        step();
        chk("acc_d_ready_t2", bus.d_req_ready, 0);
        chk("acc_i_resp", bus.i_resp_valid, 1);
        chk("acc_i_rdata", bus.i_rdata, 32'h12345678);
        chk("acc_d_rdata_idle", bus.d_rdata, 0);
        step();
        chk("acc_d_ready_t3", bus.d_req_ready, 1);
        step();
        clear();
        chk("acc_ram_addr", bus.ram_addr, 32'h40);
        chk("acc_ram_we", bus.ram_we, 0);
        step();
        chk("acc_d_resp", bus.d_resp_valid, 1);
        chk("acc_d_rdata", bus.d_rdata, 32'h12345678);
        chk("acc_i_rdata_off", bus.i_rdata, 0);
        step();

        // reset asserted while a store is in ACCESS
        bus.d_req_valid = 1'b1;
        bus.d_we        = 1'b1;
        bus.d_addr      = 32'h22;
        bus.d_wdata     = 32'h00AB0000;
        bus.d_be        = 4'b0100;
        step();
        clear();
        chk("rs_ram_we_pre", bus.ram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("rs_ram_we", bus.ram_we, 0);
        chk("rs_ram_be", bus.ram_be, 0);
        chk("rs_ram_addr", bus.ram_addr, 0);
        step();
        chk("rs_d_resp_a", bus.d_resp_valid, 0);
        rst_n = 1'b1;
        step();
        chk("rs_d_resp_b", bus.d_resp_valid, 0);
        fetch_0x10("rs_fetch");

        // data request withdrawn while the arbiter is busy
        bus.i_req_valid = 1'b1;
        bus.i_addr      = 32'h50;
        #1;
        chk("wd_i_ready", bus.i_req_ready, 1);
        step();
        bus.i_req_valid = 1'b0;
        bus.d_req_valid = 1'b1;
        bus.d_we        = 1'b1;
        bus.d_addr      = 32'h80;
        bus.d_wdata     = 32'hFFFFFFFF;
        bus.d_be        = 4'b1111;
        #1;
        chk("wd_d_ready", bus.d_req_ready, 0);
        step();
        clear();
        seen_we    = 1'b0;
        seen_dresp = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen_we    = seen_we | bus.ram_we;
            seen_dresp = seen_dresp | bus.d_resp_valid;
            step();
        end
        chk("wd_no_ram_we", seen_we, 0);
        chk("wd_no_d_resp", seen_dresp, 0);
        chk("wd_ram_addr", bus.ram_addr, 32'h50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
